// File: rtl/vga_scan_gen.sv
// vga_scan_gen: raster scan generator for the VGA display path.
// Produces pixel coordinates, active-low syncs, a visible-area qualifier,
// a pixel-rate enable and line/frame strobes plus a frame counter.
// Interface note: there is no valid/ready handshake; every output is a
// free-running status that consumers sample on any clk. Consumers with
// pipeline stages delay the syncs themselves.
module vga_scan_gen #(
  parameter int CLK_DIV  = 2,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       reset,
  output logic [8:0] row,
  output logic [9:0] col,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       pix_en,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // A one-bit divider is kept for CLK_DIV=1; it simply stays at 0.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEGIN   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEGIN   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_count;
  logic [9:0]       v_count;
  logic             h_vis;
  logic             v_vis;

  // Last clk of the current pixel period.
  assign pix_en = (div == DIV_LAST);

  // Divider, raster counters, line/frame strobes and frame counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      div         <= '0;
      h_count     <= '0;
      v_count     <= '0;
      frame_count <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        div <= '0;
        if (h_count == H_LAST) begin
          h_count    <= '0;
          line_start <= 1'b1;
          if (v_count == V_LAST) begin
            v_count     <= '0;
            frame_start <= 1'b1;
            frame_count <= frame_count + 8'd1;
          end else begin
            v_count <= v_count + 10'd1;
          end
        end else begin
          h_count <= h_count + 10'd1;
        end
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // Same-cycle decode of coordinates, visibility and syncs from the counters.
  always_comb begin
    h_vis    = (h_count < H_VIS);
    v_vis    = (v_count < V_VIS);
    video_on = h_vis && v_vis;
    col      = h_vis ? h_count : 10'd0;
    row      = v_vis ? v_count[8:0] : 9'd0;
    hsync    = !((h_count >= HS_BEGIN) && (h_count < HS_END));
    vsync    = !((v_count >= VS_BEGIN) && (v_count < VS_END));
  end

endmodule

// File: tb/tb_vga_scan_gen.sv
// tb_vga_scan_gen: directed bench for vga_scan_gen with three instances:
// default timing (a), tiny CLK_DIV=1 timing (b) and a small CLK_DIV=2
// timing (c) that makes whole frames reachable in a short run.
module tb_vga_scan_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic rst_c = 1'b1;

  logic [8:0] a_row, b_row, c_row;
  logic [9:0] a_col, b_col, c_col;
  logic       a_von, b_von, c_von;
  logic       a_hs, b_hs, c_hs;
  logic       a_vs, b_vs, c_vs;
  logic       a_pe, b_pe, c_pe;
  logic       a_ls, b_ls, c_ls;
  logic       a_fs, b_fs, c_fs;
  logic [7:0] a_fc, b_fc, c_fc;

  vga_scan_gen dut_a (
    .clk(clk), .reset(rst_a), .row(a_row), .col(a_col), .video_on(a_von),
    .hsync(a_hs), .vsync(a_vs), .pix_en(a_pe), .line_start(a_ls),
    .frame_start(a_fs), .frame_count(a_fc)
  );

  vga_scan_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_b (
    .clk(clk), .reset(rst_b), .row(b_row), .col(b_col), .video_on(b_von),
    .hsync(b_hs), .vsync(b_vs), .pix_en(b_pe), .line_start(b_ls),
    .frame_start(b_fs), .frame_count(b_fc)
  );

  vga_scan_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_c (
    .clk(clk), .reset(rst_c), .row(c_row), .col(c_col), .video_on(c_von),
    .hsync(c_hs), .vsync(c_vs), .pix_en(c_pe), .line_start(c_ls),
    .frame_start(c_fs), .frame_count(c_fc)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference raster for clk t after reset release; returns 1 on any difference.
  function automatic int model_bad(
    input int t, input int d,
    input int ha, input int hf, input int hsw, input int hb,
    input int va, input int vf, input int vsw, input int vb,
    input logic [8:0] row, input logic [9:0] col, input logic von,
    input logic hs, input logic vs, input logic pe, input logic ls,
    input logic fs, input logic [7:0] fc);
    int ht, vt, p, h, v, lines, fr;
    logic first, e_von, e_hs, e_vs, e_pe, e_ls, e_fs;
    int e_col, e_row;
    ht    = ha + hf + hsw + hb;
    vt    = va + vf + vsw + vb;
    p     = t / d;
    h     = p % ht;
    lines = p / ht;
    v     = lines % vt;
    fr    = (lines / vt) % 256;
    first = (t > 0) && ((t % d) == 0);
    e_von = (h < ha) && (v < va);
    e_col = (h < ha) ? h : 0;
    e_row = (v < va) ? v : 0;
    e_hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
    e_vs  = !((v >= va + vf) && (v < va + vf + vsw));
    e_pe  = ((t % d) == d - 1);
    e_ls  = first && (h == 0);
    e_fs  = first && (h == 0) && (v == 0);
    model_bad = 0;
    if (int'(row) != e_row || int'(col) != e_col || von !== e_von ||
        hs !== e_hs || vs !== e_vs || pe !== e_pe || ls !== e_ls ||
        fs !== e_fs || int'(fc) != fr)
      model_bad = 1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-clk reset pulse on the selected instance; returns in clk 0.
  task automatic do_reset(input int which);
    case (which)
      0: rst_a = 1'b1;
      1: rst_b = 1'b1;
      default: rst_c = 1'b1;
    endcase
    step();
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int bad;
    int hs_low;
    int vs_low;
    int pe_low;
    int fs_seen;

    // Hold all resets for a few clks, then release together.
    repeat (3) step();
    do_reset(0);

    // ---- instance a: default timing, two full lines ----
    bad = 0;
    hs_low = 0;
    exp_q.push_back(32'd1600);
    exp_q.push_back(32'd3200);
    for (int t = 0; t <= 3201; t++) begin
      bad += model_bad(t, 2, 640, 16, 96, 48, 480, 10, 2, 33,
                       a_row, a_col, a_von, a_hs, a_vs, a_pe, a_ls, a_fs, a_fc);
      if (t < 1600 && a_hs == 1'b0) hs_low++;
      if (a_ls === 1'b1) begin
        if (exp_q.size() > 0) check("a_line_start_time", 32'(t), exp_q.pop_front());
        else check("a_line_start_extra", 32'(t), 32'hFFFF_FFFF);
      end
      case (t)
        0: begin
          check("a_rst_row", 32'(a_row), 32'd0);
          check("a_rst_col", 32'(a_col), 32'd0);
          check("a_rst_video_on", 32'(a_von), 32'd1);
          check("a_rst_hsync", 32'(a_hs), 32'd1);
          check("a_rst_vsync", 32'(a_vs), 32'd1);
          check("a_rst_pix_en", 32'(a_pe), 32'd0);
          check("a_rst_line_start", 32'(a_ls), 32'd0);
          check("a_rst_frame_start", 32'(a_fs), 32'd0);
          check("a_rst_frame_count", 32'(a_fc), 32'd0);
        end
        1: begin
          check("a_clk1_pix_en", 32'(a_pe), 32'd1);
          check("a_clk1_col", 32'(a_col), 32'd0);
        end
        2: begin
          check("a_clk2_col", 32'(a_col), 32'd1);
          check("a_clk2_pix_en", 32'(a_pe), 32'd0);
        end
        1279: begin
          check("a_h639_col", 32'(a_col), 32'd639);
          check("a_h639_video_on", 32'(a_von), 32'd1);
        end
        1280: begin
          check("a_h640_col", 32'(a_col), 32'd0);
          check("a_h640_video_on", 32'(a_von), 32'd0);
        end
        1311: check("a_h655_hsync", 32'(a_hs), 32'd1);
        1312: check("a_h656_hsync", 32'(a_hs), 32'd0);
        1503: check("a_h751_hsync", 32'(a_hs), 32'd0);
        1504: check("a_h752_hsync", 32'(a_hs), 32'd1);
        1600: begin
          check("a_line1_row", 32'(a_row), 32'd1);
          check("a_line1_col", 32'(a_col), 32'd0);
        end
        default: ;
      endcase
      step();
    end
    check("a_model", 32'(bad), 32'd0);
    check("a_hsync_low_clks", 32'(hs_low), 32'd192);
    check("a_line_start_missing", 32'(exp_q.size()), 32'd0);

    // Now at clk 3202; move to clk 4600 = (h=700, v=2), inside hsync.
    repeat (1398) step();
    check("a_mid_hsync_low", 32'(a_hs), 32'd0);
    do_reset(0);
    check("a_rerst_hsync", 32'(a_hs), 32'd1);
    check("a_rerst_col", 32'(a_col), 32'd0);
    check("a_rerst_row", 32'(a_row), 32'd0);
    check("a_rerst_line_start", 32'(a_ls), 32'd0);
    check("a_rerst_pix_en", 32'(a_pe), 32'd0);
    step();
    step();
    check("a_rerst_clk2_col", 32'(a_col), 32'd1);

    // ---- instance b: CLK_DIV=1, 7x6 raster, 42 clks/frame ----
    do_reset(1);
    bad = 0;
    pe_low = 0;
    for (int t = 0; t <= 10794; t++) begin
      bad += model_bad(t, 1, 4, 1, 1, 1, 3, 1, 1, 1,
                       b_row, b_col, b_von, b_hs, b_vs, b_pe, b_ls, b_fs, b_fc);
      if (b_pe !== 1'b1) pe_low++;
      case (t)
        0: begin
          check("b_rst_pix_en", 32'(b_pe), 32'd1);
          check("b_rst_video_on", 32'(b_von), 32'd1);
        end
        42: begin
          check("b_first_frame_start", 32'(b_fs), 32'd1);
          check("b_first_frame_count", 32'(b_fc), 32'd1);
        end
        10710: begin
          check("b_fc255", 32'(b_fc), 32'd255);
          check("b_fs255", 32'(b_fs), 32'd1);
        end
        10751: check("b_fc255_hold", 32'(b_fc), 32'd255);
        10752: begin
          check("b_fc_wrap", 32'(b_fc), 32'd0);
          check("b_fs_wrap", 32'(b_fs), 32'd1);
          check("b_ls_wrap", 32'(b_ls), 32'd1);
        end
        10753: check("b_fs_one_clk", 32'(b_fs), 32'd0);
        default: ;
      endcase
      step();
    end
    check("b_model", 32'(bad), 32'd0);
    check("b_pix_en_low_clks", 32'(pe_low), 32'd0);

    // ---- instance c: CLK_DIV=2, 15x13 raster, 390 clks/frame ----
    do_reset(2);
    bad = 0;
    vs_low = 0;
    for (int t = 0; t <= 785; t++) begin
      bad += model_bad(t, 2, 8, 2, 3, 2, 6, 2, 2, 3,
                       c_row, c_col, c_von, c_hs, c_vs, c_pe, c_ls, c_fs, c_fc);
      if (t < 390 && c_vs == 1'b0) vs_low++;
      case (t)
        150: begin
          check("c_v5_row", 32'(c_row), 32'd5);
          check("c_v5_video_on", 32'(c_von), 32'd1);
        end
        180: begin
          check("c_v6_row", 32'(c_row), 32'd0);
          check("c_v6_video_on", 32'(c_von), 32'd0);
        end
        239: check("c_v7_vsync", 32'(c_vs), 32'd1);
        240: check("c_v8_vsync", 32'(c_vs), 32'd0);
        300: check("c_v10_vsync", 32'(c_vs), 32'd1);
        389: check("c_pre_frame_fs", 32'(c_fs), 32'd0);
        390: begin
          check("c_frame1_fs", 32'(c_fs), 32'd1);
          check("c_frame1_ls", 32'(c_ls), 32'd1);
          check("c_frame1_fc", 32'(c_fc), 32'd1);
        end
        780: begin
          check("c_frame2_fs", 32'(c_fs), 32'd1);
          check("c_frame2_fc", 32'(c_fc), 32'd2);
        end
        default: ;
      endcase
      step();
    end
    check("c_model", 32'(bad), 32'd0);
    check("c_vsync_low_clks", 32'(vs_low), 32'd60);

    // Now at clk 786; clk 1042 is pixel 521 = (h=11, v=8): in both syncs.
    repeat (256) step();
    check("c_mid_sync_hsync", 32'(c_hs), 32'd0);
    check("c_mid_sync_vsync", 32'(c_vs), 32'd0);
    check("c_mid_sync_fc", 32'(c_fc), 32'd2);
    do_reset(2);
    check("c_rerst_hsync", 32'(c_hs), 32'd1);
    check("c_rerst_vsync", 32'(c_vs), 32'd1);
    check("c_rerst_fc", 32'(c_fc), 32'd0);
    bad = 0;
    fs_seen = 0;
    for (int t = 0; t <= 390; t++) begin
      bad += model_bad(t, 2, 8, 2, 3, 2, 6, 2, 2, 3,
                       c_row, c_col, c_von, c_hs, c_vs, c_pe, c_ls, c_fs, c_fc);
      if (t < 390 && c_fs !== 1'b0) fs_seen++;
      if (t == 390) check("c_rerst_frame_fs", 32'(c_fs), 32'd1);
      step();
    end
    check("c_rerst_model", 32'(bad), 32'd0);
    check("c_rerst_no_early_fs", 32'(fs_seen), 32'd0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
